tt_um_emern_load_sched: RTL

//  Sits between the SPI frontend and the rasteriser and schedules both of them.
//  - Opens the frontend's SPI load window (en_load) only during blanking.
//  - Holds a shadow copy of all polygon/background state.
//  - Commits that copy once per frame at vertical blank, so the raster never tears.
//  - A commit is deferred while an SPI transfer is in flight (cs low).

---
 rtl/tt_um_emern_load_sched_pkg.sv | 52 +++++
 rtl/tt_um_emern_sync_ff.sv | 54 +++++
 rtl/tt_um_emern_load_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_emern_load_sched_pkg.sv
// ---------------------------------------------------------------------------
// tt_um_emern_load_sched_pkg
//
// Purpose:
//   Shared definitions for the load scheduler. It holds the FSM state
//   encoding, the field widths of the polygon/background state, and the
//   packed layout of the shadow copy.
//
// Contents:
//   ST_ACTIVE / ST_VB_WAIT / ST_COMMIT / ST_VB_DONE  FSM encodings (2 bits)
//   COLOR_W, X_W, Y_W, NPOLY                         per-polygon field widths
//   SHADOW_W                                         total shadowed bits (98)
//   shadow_t                                         packed shadow record
//   sat_inc4                                         saturating helper
// ---------------------------------------------------------------------------
package tt_um_emern_load_sched_pkg;

  // FSM state encoding.
  localparam logic [1:0] ST_ACTIVE  = 2'd0;
  localparam logic [1:0] ST_VB_WAIT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  localparam logic [1:0] ST_VB_DONE = 2'd3;

  // Field widths. Multi-polygon buses are packed {B,A}.
  localparam int COLOR_W = 6;
  localparam int X_W     = 7;
  localparam int Y_W     = 6;
  localparam int NPOLY   = 2;

  localparam int SHADOW_W = COLOR_W + NPOLY * COLOR_W + 3 * NPOLY * X_W
                          + 3 * NPOLY * Y_W + NPOLY;

  // Field order matters only for the dirty compare and the output unpack;
  // both use this one definition.
  typedef struct packed {
    logic [COLOR_W-1:0]       bg_color;
    logic [NPOLY*COLOR_W-1:0] poly_color;
    logic [NPOLY*X_W-1:0]     v0_x;
    logic [NPOLY*X_W-1:0]     v1_x;
    logic [NPOLY*X_W-1:0]     v2_x;
    logic [NPOLY*Y_W-1:0]     v0_y;
    logic [NPOLY*Y_W-1:0]     v1_y;
    logic [NPOLY*Y_W-1:0]     v2_y;
    logic [NPOLY-1:0]         poly_enable;
  } shadow_t;

  // Saturating 4-bit increment, handy for small event counters.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tt_um_emern_sync_ff.sv
// ---------------------------------------------------------------------------
// tt_um_emern_sync_ff
//
// Purpose:
//   N-stage flop synchroniser for a single asynchronous level signal, with a
//   configurable reset value so idle-high signals (such as an active-low chip
//   select) read as idle straight out of reset.
//
// Parameters:
//   STAGES   number of flops in the chain (2 or more)
//   RST_VAL  value loaded into every stage while rst_n is low
//
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  synchronous active-low reset
//   d_in   in  1  asynchronous input
//   q_out  out 1  synchronised output (last stage)
// ---------------------------------------------------------------------------
module tt_um_emern_sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Stage 0 samples the raw input; every later stage samples its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_d[gi] = d_in;
      end else begin : g_rest
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/tt_um_emern_load_sched.sv
// ---------------------------------------------------------------------------
// tt_um_emern_load_sched
//
// Purpose:
//   Schedules the SPI frontend and the rasteriser. The frontend load window
//   (en_load_out) is only opened during blanking. A shadow copy of all
//   polygon/background state is committed at most once per frame on the
//   rising edge of vertical blank, so the raster never tears. If an SPI
//   transfer is in flight (cs low) the commit waits inside the same vertical
//   blank; if blanking ends first the frame is counted as deferred.
//
// Build option:
//   LOAD_SCHED_DISPLAY_OFF_EN  when defined, display off makes the shadow
//                              transparent and keeps the load window open;
//                              when undefined, display off freezes the
//                              shadow and closes the load window.
//
// Parameters:
//   CS_SYNC_STAGES  synchroniser depth for cs_in (2 or more)
//   DEFER_CNT_W     width of the saturating deferred-commit counter
//
// Ports:
//   clk                in   1   system clock
//   rst_n              in   1   synchronous active-low reset
//   h_blank_in         in   1   horizontal blanking
//   v_blank_in         in   1   vertical blanking
//   display_en_in      in   1   display enabled (low = display off)
//   cs_in              in   1   raw SPI chip select (async, active-low)
//   bg_color_in        in   6   frontend background colour
//   poly_color_in      in   12  frontend colours {B,A}
//   v{0,1,2}_x_in      in   14  frontend vertex x {B,A}
//   v{0,1,2}_y_in      in   12  frontend vertex y {B,A}
//   poly_enable_in     in   2   frontend polygon enables
//   en_load_out        out  1   load window to the frontend
//   *_out              out  =   shadow copy of each *_in
//   commit_pulse_out   out  1   high for the cycle the new shadow appears
//   deferred_cnt_out   out  DEFER_CNT_W  missed-commit frames, saturating
// ---------------------------------------------------------------------------
module tt_um_emern_load_sched
  import tt_um_emern_load_sched_pkg::*;
#(
  parameter int CS_SYNC_STAGES = 2,
  parameter int DEFER_CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      h_blank_in,
  input  logic                      v_blank_in,
  input  logic                      display_en_in,
  input  logic                      cs_in,
  input  logic [COLOR_W-1:0]        bg_color_in,
  input  logic [NPOLY*COLOR_W-1:0]  poly_color_in,
  input  logic [NPOLY*X_W-1:0]      v0_x_in,
  input  logic [NPOLY*X_W-1:0]      v1_x_in,
  input  logic [NPOLY*X_W-1:0]      v2_x_in,
  input  logic [NPOLY*Y_W-1:0]      v0_y_in,
  input  logic [NPOLY*Y_W-1:0]      v1_y_in,
  input  logic [NPOLY*Y_W-1:0]      v2_y_in,
  input  logic [NPOLY-1:0]          poly_enable_in,
  output logic                      en_load_out,
  output logic [COLOR_W-1:0]        bg_color_out,
  output logic [NPOLY*COLOR_W-1:0]  poly_color_out,
  output logic [NPOLY*X_W-1:0]      v0_x_out,
  output logic [NPOLY*X_W-1:0]      v1_x_out,
  output logic [NPOLY*X_W-1:0]      v2_x_out,
  output logic [NPOLY*Y_W-1:0]      v0_y_out,
  output logic [NPOLY*Y_W-1:0]      v1_y_out,
  output logic [NPOLY*Y_W-1:0]      v2_y_out,
  output logic [NPOLY-1:0]          poly_enable_out,
  output logic                      commit_pulse_out,
  output logic [DEFER_CNT_W-1:0]    deferred_cnt_out
);

  // -------------------------------------------------------------------------
  // Chip-select synchroniser: idles high so we come out of reset not busy.
  // -------------------------------------------------------------------------
  logic cs_sync;
  logic busy;

  tt_um_emern_sync_ff #(
    .STAGES (CS_SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (cs_in),
    .q_out(cs_sync)
  );

  assign busy = ~cs_sync;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]             state_q,    state_d;
  logic                   vb_q,       vb_d;
  shadow_t                shadow_q,   shadow_d;
  logic [DEFER_CNT_W-1:0] defer_q,    defer_d;
  logic                   en_load_q,  en_load_d;
  logic                   pulse_q,    pulse_d;

  shadow_t in_s;
  logic    dirty;
  logic    vb_rise;

  assign in_s = {bg_color_in, poly_color_in,
                 v0_x_in, v1_x_in, v2_x_in,
                 v0_y_in, v1_y_in, v2_y_in,
                 poly_enable_in};

  assign dirty   = (in_s != shadow_q);
  assign vb_rise = v_blank_in & ~vb_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    defer_d  = defer_q;
    pulse_d  = 1'b0;
    vb_d     = v_blank_in;

    if (!display_en_in) begin
      // Display off parks the scheduler; a commit in progress is abandoned.
      state_d = ST_ACTIVE;
`ifdef LOAD_SCHED_DISPLAY_OFF_EN
      shadow_d = in_s;
`endif
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (vb_rise) begin
            if (!dirty) begin
              state_d = ST_VB_DONE;
            end else if (busy) begin
              state_d = ST_VB_WAIT;
            end else begin
              state_d = ST_COMMIT;
            end
          end
        end
        ST_VB_WAIT: begin
          // Blanking ending takes priority over the transfer finishing in
          // the same cycle: the frame is lost either way.
          if (!v_blank_in) begin
            state_d = ST_ACTIVE;
            if (defer_q != {DEFER_CNT_W{1'b1}}) begin
              defer_d = defer_q + 1'b1;
            end
          end else if (!busy) begin
            state_d = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state_d = ST_VB_DONE;
        end
        ST_VB_DONE: begin
          // A second vb_rise here is ignored; only the fall re-arms.
          if (!v_blank_in) begin
            state_d = ST_ACTIVE;
          end
        end
        default: begin
          state_d = ST_ACTIVE;
        end
      endcase
    end

    // The snapshot is captured on the edge that enters COMMIT, so the new
    // shadow and the pulse both become visible during the COMMIT cycle.
    if (state_d == ST_COMMIT) begin
      shadow_d = in_s;
      pulse_d  = 1'b1;
    end
  end

  // Load window: closed whenever the next cycle is the commit snapshot.
  always_comb begin
`ifdef LOAD_SCHED_DISPLAY_OFF_EN
    if (!display_en_in) begin
      en_load_d = 1'b1;
    end else begin
      en_load_d = (h_blank_in | v_blank_in) & (state_d != ST_COMMIT);
    end
`else
    en_load_d = (h_blank_in | v_blank_in) & display_en_in & (state_d != ST_COMMIT);
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ACTIVE;
      vb_q      <= 1'b0;
      shadow_q  <= '0;
      defer_q   <= '0;
      en_load_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vb_q      <= vb_d;
      shadow_q  <= shadow_d;
      defer_q   <= defer_d;
      en_load_q <= en_load_d;
      pulse_q   <= pulse_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign en_load_out      = en_load_q;
  assign commit_pulse_out = pulse_q;
  assign deferred_cnt_out = defer_q;

  assign bg_color_out    = shadow_q.bg_color;
  assign poly_color_out  = shadow_q.poly_color;
  assign v0_x_out        = shadow_q.v0_x;
  assign v1_x_out        = shadow_q.v1_x;
  assign v2_x_out        = shadow_q.v2_x;
  assign v0_y_out        = shadow_q.v0_y;
  assign v1_y_out        = shadow_q.v1_y;
  assign v2_y_out        = shadow_q.v2_y;
  assign poly_enable_out = shadow_q.poly_enable;

endmodule
